// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register countdown armed on issue; HAZARD_PERF_EN adds a stall counter.
// Latency: stall is combinational from IF/ID fields and counters; counters update one edge after issue.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX until every source counter is within slack.
module hazard_scoreboard #(
  parameter int REG_AW   = 4,
  parameter int CNT_W    = 2,
  parameter int ALU_LAT  = 1,
  parameter int LD_LAT   = 2,
  parameter int MUL_LAT  = 3,
  parameter int LONG_LAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifid_valid,
  input  logic [REG_AW-1:0]     ifid_rs,
  input  logic [REG_AW-1:0]     ifid_rt,
  input  logic                  ifid_br,
  input  logic                  ifid_rw,
  input  logic [REG_AW-1:0]     ifid_rd,
  input  logic [1:0]            ifid_cls,
  input  logic                  flush,
  output logic                  stall,
  output logic [2**REG_AW-1:0]  pending,
  output logic [31:0]           stall_cnt
);

  localparam int NREGS = 2**REG_AW;

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [CNT_W-1:0] slack;
  logic [CNT_W-1:0] arm_lat;
  logic             hazard_rs;
  logic             hazard_rt;
  logic             issue;

  function automatic logic [CNT_W-1:0] lat_of(input logic [1:0] cls);
    case (cls)
      2'd0:    lat_of = CNT_W'(ALU_LAT);
      2'd1:    lat_of = CNT_W'(LD_LAT);
      2'd2:    lat_of = CNT_W'(MUL_LAT);
      default: lat_of = CNT_W'(LONG_LAT);
    endcase
  endfunction

  assign slack     = ifid_br ? '0 : CNT_W'(1);
  assign hazard_rs = (ifid_rs != '0) && (cnt[ifid_rs] > slack);
  assign hazard_rt = (ifid_rt != '0) && (cnt[ifid_rt] > slack);
  assign stall     = ifid_valid & ~flush & ~rst & (hazard_rs | hazard_rt);
  assign issue     = ifid_valid & ~flush & ~stall & ~rst;
  assign arm_lat   = lat_of(ifid_cls);

  // Arming takes the max so a younger short producer never shortens an older long one.
  always_comb begin
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      cnt_nxt[r] = (cnt[r] != '0) ? cnt[r] - CNT_W'(1) : '0;
      if (issue && ifid_rw && (ifid_rd == REG_AW'(r)) && (arm_lat > cnt_nxt[r]))
        cnt_nxt[r] = arm_lat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '{default: '0};
    else     cnt <= cnt_nxt;
  end

  always_comb begin
    pending = '0;
    for (int r = 0; r < NREGS; r++) pending[r] = (cnt[r] != '0);
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)                                 stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: producer/consumer vector table plus hand sequences for WAW, flush and reset.
module tb_hazard_scoreboard;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ifid_valid;
  logic [3:0]  ifid_rs, ifid_rt, ifid_rd;
  logic        ifid_br, ifid_rw;
  logic [1:0]  ifid_cls;
  logic        flush;
  logic        stall;
  logic [15:0] pending;
  logic [31:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .ifid_valid(ifid_valid), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_br(ifid_br), .ifid_rw(ifid_rw), .ifid_rd(ifid_rd), .ifid_cls(ifid_cls),
    .flush(flush), .stall(stall), .pending(pending), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [1:0] cls;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       br;
    int         gap;
    int         exp_stalls;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [3:0] rs, input logic [3:0] rt, input logic br,
                       input logic rw, input logic [3:0] rd, input logic [1:0] cls, input logic fl);
    ifid_valid = v; ifid_rs = rs; ifid_rt = rt; ifid_br = br;
    ifid_rw = rw; ifid_rd = rd; ifid_cls = cls; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
  endtask

  // Issues a producer that must not stall, then advances one cycle.
  task automatic produce(input string name, input logic [3:0] rd, input logic [1:0] cls);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, rd, cls, 1'b0);
    #1 check({name, "_prod_stall"}, 32'(stall), 32'd0);
    tick();
  endtask

  // Holds a consumer in ID until it issues, counting stall cycles against the queued expectation.
  task automatic consume(input string name, input logic [3:0] rs, input logic [3:0] rt,
                         input logic br, input int exp_stalls);
    int cycles;
    int exp;
    exp_q.push_back(exp_stalls);
    drive(1'b1, rs, rt, br, 1'b0, 4'd0, 2'd0, 1'b0);
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!stall) break;
      cycles++;
      tick();
    end
    exp = exp_q.pop_front();
    check({name, "_stalls"}, 32'(cycles), 32'(exp));
    tick();
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               cls   rd     rs     rt     br    gap exp
    tbl[0]  = '{2'd1, 4'd3,  4'd3,  4'd0,  1'b0, 0, 1};
    tbl[1]  = '{2'd1, 4'd5,  4'd5,  4'd0,  1'b1, 0, 2};
    tbl[2]  = '{2'd0, 4'd5,  4'd0,  4'd5,  1'b1, 0, 1};
    tbl[3]  = '{2'd0, 4'd5,  4'd5,  4'd0,  1'b0, 0, 0};
    tbl[4]  = '{2'd2, 4'd7,  4'd0,  4'd7,  1'b0, 0, 2};
    tbl[5]  = '{2'd2, 4'd7,  4'd7,  4'd0,  1'b1, 0, 3};
    tbl[6]  = '{2'd3, 4'd9,  4'd0,  4'd9,  1'b1, 1, 2};
    tbl[7]  = '{2'd2, 4'd2,  4'd2,  4'd0,  1'b0, 1, 1};
    tbl[8]  = '{2'd1, 4'd0,  4'd0,  4'd0,  1'b0, 0, 0};
    tbl[9]  = '{2'd1, 4'd6,  4'd4,  4'd0,  1'b0, 0, 0};
    tbl[10] = '{2'd3, 4'd15, 4'd15, 4'd15, 1'b0, 2, 0};
    tbl[11] = '{2'd1, 4'd8,  4'd1,  4'd8,  1'b1, 0, 2};

    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      tick();
    end

    for (int v = 0; v < 12; v++) begin
      idle();
      repeat (4) tick();
      #1 check($sformatf("vec%0d_drained", v), 32'(pending), 32'd0);
      produce($sformatf("vec%0d", v), tbl[v].rd, tbl[v].cls);
      idle();
      for (int g = 0; g < tbl[v].gap; g++) tick();
      consume($sformatf("vec%0d", v), tbl[v].rs, tbl[v].rt, tbl[v].br, tbl[v].exp_stalls);
    end

    // Load into r3: pending[3] visible exactly two cycles, add stalls in the first only.
    repeat (4) tick();
    produce("ld3", 4'd3, 2'd1);
    drive(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
    #1 check("ld3_c1_stall", 32'(stall), 32'd1);
    check("ld3_c1_pend", 32'(pending[3]), 32'd1);
    tick();
    #1 check("ld3_c2_stall", 32'(stall), 32'd0);
    check("ld3_c2_pend", 32'(pending[3]), 32'd1);
    tick();
    idle();
    #1 check("ld3_c3_pend", 32'(pending[3]), 32'd0);

    // WAW: younger ALU write must not shorten the older mul.
    repeat (4) tick();
    produce("waw_mul", 4'd7, 2'd2);
    produce("waw_alu", 4'd7, 2'd0);
    consume("waw_br", 4'd7, 4'd0, 1'b1, 2);

    // r0 never arms; flushed producer never arms.
    repeat (4) tick();
    produce("r0_ld", 4'd0, 2'd1);
    idle();
    #1 check("r0_pend", 32'(pending), 32'd0);
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 2'd1, 1'b1);
    #1 check("flush_stall", 32'(stall), 32'd0);
    tick();
    idle();
    #1 check("flush_pend", 32'(pending), 32'd0);
    consume("flush_br", 4'd4, 4'd0, 1'b1, 0);

    // Reset in the middle of a load->branch stall.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    produce("mid_ld", 4'd5, 2'd1);
    drive(1'b1, 4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
    #1 check("mid_c1_stall", 32'(stall), 32'd1);
    check("mid_c1_cnt", stall_cnt, 32'd0);
    tick();
    #1 check("mid_c2_stall", 32'(stall), 32'd1);
    check("mid_c2_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
    rst = 1'b1;
    #1 check("mid_rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1'b0;
    #1 check("mid_after_stall", 32'(stall), 32'd0);
    check("mid_after_pend", 32'(pending), 32'd0);
    check("mid_after_cnt", stall_cnt, 32'd0);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
